// File: rtl/rat_mem_pkg.sv
// Shared constants and loader state type for the program-memory sequencing logic.
package rat_mem_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 18;
    localparam int unsigned DEPTH  = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        VWAIT,
        FIN
    } prog_ld_state_t;

endpackage

// File: rtl/csum_acc.sv
// Modular accumulator with synchronous clear (priority) and enable; wraps silently at W bits.
module csum_acc #(
    parameter int unsigned W = rat_mem_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    logic [W-1:0] sum_q;
    logic [W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = sum_q + din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Program-memory sequencer: MCU fetch passthrough, streamed load with checksum, readback verify.
module prog_loader
    import rat_mem_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W:0]   LEN,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [ADDR_W-1:0] FETCH_ADDR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              CPU_RST,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [DATA_W-1:0] CHECKSUM
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    prog_ld_state_t    state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              rv_q, rv_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              err_q, err_d;

    logic              csum_clr, csum_en;
    logic              rsum_clr;
    logic [DATA_W-1:0] csum, rsum;
    logic              len_ok;
    logic              last_cnt;

    assign len_ok   = (LEN != '0) && (LEN <= LEN_W'(DEPTH));
    // Counter is one bit wider than the address so LEN=DEPTH reaches DEPTH-1 without wrapping.
    assign last_cnt = (cnt_q == (len_q - LEN_W'(1)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        rv_d      = 1'b0;
        cpu_rst_d = cpu_rst_q;
        err_d     = err_q;
        csum_clr  = 1'b0;
        csum_en   = 1'b0;
        rsum_clr  = 1'b0;
        IN_READY  = 1'b0;
        MEM_WE    = 1'b0;
        MEM_WDATA = '0;
        MEM_ADDR  = cnt_q[ADDR_W-1:0];
        BUSY      = 1'b0;
        DONE      = 1'b0;

        case (state_q)
            IDLE: begin
                MEM_ADDR = FETCH_ADDR;
                if (START) begin
                    if (len_ok) begin
                        len_d     = LEN;
                        cnt_d     = '0;
                        csum_clr  = 1'b1;
                        rsum_clr  = 1'b1;
                        err_d     = 1'b0;
                        cpu_rst_d = 1'b1;
                        state_d   = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                BUSY     = 1'b1;
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    MEM_WE    = 1'b1;
                    MEM_WDATA = IN_DATA;
                    csum_en   = 1'b1;
                    if (last_cnt) begin
                        cnt_d   = '0;
                        state_d = VERIFY;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            VERIFY: begin
                BUSY = 1'b1;
                // Read data for this address arrives next cycle; rv_q marks it for accumulation.
                rv_d = 1'b1;
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = VWAIT;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            VWAIT: begin
                BUSY    = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                MEM_ADDR  = FETCH_ADDR;
                DONE      = 1'b1;
                cpu_rst_d = 1'b0;
                if (rsum != csum) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            rv_q      <= 1'b0;
            cpu_rst_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rv_q      <= rv_d;
            cpu_rst_q <= cpu_rst_d;
            err_q     <= err_d;
        end
    end

    csum_acc #(.W(DATA_W)) u_load_sum (
        .clk (CLK),
        .rst (RST),
        .clr (csum_clr),
        .en  (csum_en),
        .din (IN_DATA),
        .sum (csum)
    );

    csum_acc #(.W(DATA_W)) u_read_sum (
        .clk (CLK),
        .rst (RST),
        .clr (rsum_clr),
        .en  (rv_q),
        .din (MEM_RDATA),
        .sum (rsum)
    );

    assign CPU_RST  = cpu_rst_q;
    assign ERR      = err_q;
    assign CHECKSUM = csum;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: driver queues expected writes/completions, monitor checks them.
module tb_prog_loader;

    localparam int AW  = 10;
    localparam int DW  = 18;
    localparam int DEP = 1024;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [AW:0]   LEN;
    logic [DW-1:0] IN_DATA;
    logic          IN_VALID;
    logic          IN_READY;
    logic [AW-1:0] FETCH_ADDR;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_WE;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic          CPU_RST;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [DW-1:0] CHECKSUM;

    always #5 CLK = ~CLK;

    prog_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .LEN        (LEN),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .FETCH_ADDR (FETCH_ADDR),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WE     (MEM_WE),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA),
        .CPU_RST    (CPU_RST),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR),
        .CHECKSUM   (CHECKSUM)
    );

    // Synchronous-read memory; optional bit-0 corruption of address 2 on readback.
    logic [DW-1:0] mem [DEP];
    bit            corrupt = 1'b0;

    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
        MEM_RDATA <= mem[MEM_ADDR] ^ ((corrupt && MEM_ADDR == 10'd2) ? 18'h1 : 18'h0);
    end

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [DW-1:0] csum;
        bit            err;
        int            k;
        int            len;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    done_cnt = 0;
    bit    err_pend = 1'b0;
    bit    exp_err_pend = 1'b0;
    logic [DW-1:0] wbuf [DEP];
    bit    pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        wr_t   w;
        done_t d;
        forever begin
            @(negedge CLK);
            #2;
            if (!RST) begin
                if (err_pend) begin
                    chk("err_after_done", 32'(ERR), 32'(exp_err_pend));
                    chk("cpu_rst_released", 32'(CPU_RST), 32'(0));
                    err_pend = 1'b0;
                end
                if (MEM_WE) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_write", 32'(MEM_WE), 32'(0));
                    end else begin
                        w = wq.pop_front();
                        chk("wr_addr", 32'(MEM_ADDR), 32'(w.addr));
                        chk("wr_data", 32'(MEM_WDATA), 32'(w.data));
                        chk("cpu_rst_in_load", 32'(CPU_RST), 32'(1));
                    end
                end
                if (DONE) begin
                    if (dq.size() == 0) begin
                        chk("unexpected_done", 32'(DONE), 32'(0));
                    end else begin
                        d = dq.pop_front();
                        chk("checksum", 32'(CHECKSUM), 32'(d.csum));
                        chk("done_latency", 32'(cyc - d.k), 32'(d.len + 2));
                        chk("fin_addr_mux", 32'(MEM_ADDR), 32'(FETCH_ADDR));
                        chk("writes_drained", 32'(wq.size()), 32'(0));
                        exp_err_pend = d.err;
                        err_pend = 1'b1;
                    end
                    done_cnt++;
                end
            end
        end
    end

    task automatic run_load(input int len, input int vmode, input bit exp_err, input int rst_after);
        logic [DW-1:0] sum;
        int  i, g, p, k, w0, wt;
        bit  v, acc;
        sum = '0;
        for (int j = 0; j < len; j++) sum = sum + wbuf[j];
        @(negedge CLK);
        START = 1'b1;
        LEN = 11'(len);
        FETCH_ADDR = 10'($urandom);
        @(negedge CLK);
        START = 1'b0;
        chk("busy_after_start", 32'(BUSY), 32'(1));
        chk("cpu_rst_after_start", 32'(CPU_RST), 32'(1));
        chk("err_cleared", 32'(ERR), 32'(0));
        chk("csum_cleared", 32'(CHECKSUM), 32'(0));
        i = 0; g = 0; p = 0; k = 0;
        while (i < len && g < 8 * len + 100) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = pat[p % 6];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            p++;
            g++;
            IN_VALID = v;
            IN_DATA  = v ? wbuf[i] : 18'($urandom);
            acc = v && (IN_READY === 1'b1);
            if (acc) begin
                wq.push_back('{i, wbuf[i]});
                k = cyc;
            end
            @(negedge CLK);
            if (acc) i++;
            if (rst_after > 0 && i == rst_after) begin
                IN_VALID = 1'b0;
                #1 RST = 1'b1;
                #1;
                chk("rst_in_ready", 32'(IN_READY), 32'(0));
                chk("rst_mem_we", 32'(MEM_WE), 32'(0));
                chk("rst_cpu_rst", 32'(CPU_RST), 32'(0));
                chk("rst_busy", 32'(BUSY), 32'(0));
                chk("rst_done", 32'(DONE), 32'(0));
                chk("rst_err", 32'(ERR), 32'(0));
                chk("rst_checksum", 32'(CHECKSUM), 32'(0));
                chk("rst_idle_addr_mux", 32'(MEM_ADDR), 32'(FETCH_ADDR));
                wq.delete();
                #1 RST = 1'b0;
                return;
            end
        end
        IN_VALID = 1'b0;
        if (i < len) begin
            chk("load_timeout", 32'(i), 32'(len));
            wq.delete();
            return;
        end
        dq.push_back('{sum, exp_err, k, len});
        w0 = done_cnt;
        wt = 0;
        while (done_cnt == w0 && wt < len + 20) begin
            @(negedge CLK);
            wt++;
        end
        if (done_cnt == w0) begin
            chk("done_timeout", 32'(done_cnt), 32'(w0 + 1));
            dq.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic illegal_start(input int len);
        @(negedge CLK);
        START = 1'b1;
        LEN = 11'(len);
        @(negedge CLK);
        START = 1'b0;
        chk("illegal_err", 32'(ERR), 32'(1));
        chk("illegal_busy", 32'(BUSY), 32'(0));
        chk("illegal_cpu_rst", 32'(CPU_RST), 32'(0));
        chk("illegal_in_ready", 32'(IN_READY), 32'(0));
    endtask

    initial begin
        int n;
        RST = 1'b1;
        START = 1'b0;
        LEN = '0;
        IN_DATA = '0;
        IN_VALID = 1'b0;
        FETCH_ADDR = '0;
        repeat (2) @(negedge CLK);
        chk("reset_in_ready", 32'(IN_READY), 32'(0));
        chk("reset_cpu_rst", 32'(CPU_RST), 32'(0));
        chk("reset_busy", 32'(BUSY), 32'(0));
        chk("reset_err", 32'(ERR), 32'(0));
        chk("reset_checksum", 32'(CHECKSUM), 32'(0));
        RST = 1'b0;

        // Fetch passthrough; a stray IN_VALID in IDLE is not accepted.
        @(negedge CLK);
        FETCH_ADDR = 10'h155;
        IN_VALID = 1'b1;
        #1;
        chk("fetch_passthrough", 32'(MEM_ADDR), 32'h155);
        chk("idle_no_we", 32'(MEM_WE), 32'(0));
        chk("idle_cpu_rst", 32'(CPU_RST), 32'(0));
        chk("idle_in_ready", 32'(IN_READY), 32'(0));
        IN_VALID = 1'b0;

        wbuf[0] = 18'h00001; wbuf[1] = 18'h3FFFF; wbuf[2] = 18'h12345; wbuf[3] = 18'h00010;
        run_load(4, 0, 1'b0, 0);
        run_load(3, 1, 1'b0, 0);

        illegal_start(0);
        illegal_start(1025);
        wbuf[0] = 18'($urandom);
        run_load(1, 0, 1'b0, 0);

        for (int j = 0; j < 5; j++) wbuf[j] = 18'($urandom);
        corrupt = 1'b1;
        run_load(5, 2, 1'b1, 0);
        corrupt = 1'b0;

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 40);
            for (int j = 0; j < n; j++) wbuf[j] = 18'($urandom);
            run_load(n, 2, 1'b0, 0);
        end

        for (int j = 0; j < DEP; j++) wbuf[j] = 18'($urandom);
        run_load(DEP, 2, 1'b0, 0);

        run_load(300, 0, 1'b0, 100);
        repeat (2) @(negedge CLK);
        wbuf[0] = 18'h2AAAA; wbuf[1] = 18'h15556;
        run_load(2, 0, 1'b0, 0);

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Sequences the 1024x18 synchronous-read program memory.
- Normal operation: passes the MCU program-counter fetch address straight through to the memory.
- On command, holds the MCU in reset and streams LEN 18-bit words from a valid/ready source (UART bootloader) into memory at addresses 0..LEN-1.
- After loading, reads back every loaded word, compares the checksums, then releases the MCU.

Parameters:
- ADDR_W, 10, memory address width.
- DATA_W, 18, instruction word width.
- DEPTH, 1024, number of memory words; LEN must be in 1..DEPTH.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle load request; sampled only in IDLE.
- LEN  in  ADDR_W+1  number of words to load; latched on an accepted START.
- IN_DATA  in  DATA_W  incoming instruction word.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  loader accepts a word this cycle.
- FETCH_ADDR  in  ADDR_W  MCU program-counter fetch address.
- MEM_ADDR  out  ADDR_W  program memory address.
- MEM_WE  out  1  program memory write enable.
- MEM_WDATA  out  DATA_W  program memory write data.
- MEM_RDATA  in  DATA_W  program memory read data; valid one cycle after its address is presented.
- CPU_RST  out  1  holds the MCU in reset.
- BUSY  out  1  high in LOAD, VERIFY and VWAIT.
- DONE  out  1  one-cycle pulse when a load completes.
- ERR  out  1  sticky error flag; cleared by the next accepted START.
- CHECKSUM  out  DATA_W  sum of all loaded words, mod 2^DATA_W.

Behaviour:
- Reset values (asynchronous): state=IDLE, word counter=0, IN_READY=0, MEM_WE=0, CPU_RST=0, BUSY=0, DONE=0, ERR=0, CHECKSUM=0. Readback sum=0.
- States: IDLE, LOAD, VERIFY, VWAIT, FIN.
- Address mux:
  - MEM_ADDR=FETCH_ADDR in IDLE and FIN; MEM_ADDR=counter otherwise.
  - This is combinational, so MCU fetch latency through the memory is unchanged (1 cycle).
- IDLE:
  - START=1 with 1<=LEN<=DEPTH: latch LEN, clear counter, CHECKSUM, readback sum and ERR; go to LOAD.
  - START=1 with LEN=0 or LEN>DEPTH: set ERR, stay in IDLE, no memory access.
- LOAD:
  - IN_READY=1 (combinational from state).
  - Handshake on IN_VALID&IN_READY:
    - MEM_WE=1, MEM_WDATA=IN_DATA, MEM_ADDR=counter in the same cycle.
    - CHECKSUM+=IN_DATA, wrapping mod 2^18.
    - Counter increments.
  - IN_VALID low: no write, no stall penalty.
  - Last word accepted (counter==LEN-1): counter cleared, go to VERIFY.
- VERIFY:
  - Each cycle presents address=counter, MEM_WE=0, and increments the counter.
  - Readback data is accumulated one cycle later (tracked by a delayed-valid flag).
  - Once address LEN-1 has been issued, go to VWAIT.
- VWAIT: one cycle to accumulate the final readback word, then go to FIN.
- FIN (single cycle):
  - DONE=1.
  - ERR=1 if the readback sum != CHECKSUM.
  - CPU_RST deasserts on the next edge.
  - Next state is IDLE.
- CPU_RST is registered:
  - Asserts on the edge entering LOAD.
  - Deasserts on the edge leaving FIN.
  - ERR does not keep the MCU held.
- Total load latency: LEN accepted beats + LEN + 2 cycles.
- Overlap and boundary rules:
  - START outside IDLE is ignored.
  - IN_VALID outside LOAD is ignored and never consumed.
  - LEN=DEPTH: the last write is to address 1023. The counter must not wrap before the state change; the counter is ADDR_W+1 bits wide.
  - Simultaneous START and RST: RST wins.
  - RST mid-LOAD or mid-VERIFY: immediate return to IDLE with CPU_RST=0. Memory contents are partially written; the higher-level reset logic is responsible.
  - Checksum and readback sum wrap silently at 18 bits.

Decomposition:
- Shared package rat_mem_pkg:
  - ADDR_W, DATA_W, DEPTH constants.
  - prog_ld_state_t enum {IDLE, LOAD, VERIFY, VWAIT, FIN}.
- One sub-module: csum_acc. It is an 18-bit modular accumulator with clear and enable, instantiated twice (load sum and readback sum).
- The FSM, counter and address mux stay in prog_loader.

Test Plan:
- Fetch passthrough: in IDLE, drive FETCH_ADDR=0x155 -> MEM_ADDR=0x155 the same cycle, MEM_WE=0, CPU_RST=0.
- Basic load, LEN=4, words 0x00001, 0x3FFFF, 0x12345, 0x00010, IN_VALID continuous:
  - Writes land at addresses 0..3 on consecutive cycles.
  - CHECKSUM=0x12355.
  - DONE pulses exactly 6 cycles after the last write handshake.
  - ERR=0, CPU_RST high for the whole sequence.
- Back-pressure: LEN=3 with IN_VALID toggled 1,0,0,1,0,1 -> exactly 3 writes at addresses 0,1,2, no write in the idle cycles, and identical CHECKSUM.
- Verify mismatch: memory model corrupts address 2 on readback (XOR 0x1) -> FIN sets ERR=1, DONE=1, and CPU_RST still deasserts.
- Illegal length:
  - LEN=0 -> ERR=1, state stays IDLE, CPU_RST=0.
  - LEN=1025 -> same result.
  - A following START with LEN=1 clears ERR.
- Full depth and reset:
  - LEN=1024 -> last write at address 0x3FF, no write to address 0.
  - A separate run asserts RST after 100 words -> all outputs return to reset values within the same cycle and the FSM is in IDLE.
